// File: rtl/cpu_memory_access_pkg.sv
// Shared constants for the Mox125 data-memory stage: PCB bit positions,
// access-size codes, FSM encodings and the latched per-access context.
package cpu_memory_access_pkg;

  localparam int PCB_WIDTH = 5;
  localparam int PCB_WA    = 0;
  localparam int PCB_WB    = 1;
  localparam int PCB_RM    = 2;
  localparam int PCB_WM    = 3;
  localparam int PCB_SPARE = 4;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_S = 2'b01;
  localparam logic [1:0] SIZE_L = 2'b10;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUS  = 1'b1;

  // Instruction context held while the bus cycle is outstanding.
  typedef struct packed {
    logic        wa;
    logic        wb;
    logic        load;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic [3:0]  idx0;
    logic [3:0]  idx1;
    logic [1:0]  size;
    logic [1:0]  off;
  } mem_op_t;

endpackage

// File: rtl/cpu_memory_access_lane.sv
// Big-endian byte-lane steering: size/offset -> select, store replication,
// misalignment detect, and zero-extended load extraction.
module cpu_mem_lane
  import cpu_memory_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rd_data_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdat_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  always_comb begin
    sel_o      = 4'b1111;
    wdat_o     = st_data_i;
    misalign_o = 1'b0;
    case (size_i)
      SIZE_B: begin
        sel_o  = 4'b1000 >> off_i;
        wdat_o = {4{st_data_i[7:0]}};
      end
      SIZE_S: begin
        sel_o      = off_i[1] ? 4'b0011 : 4'b1100;
        wdat_o     = {2{st_data_i[15:0]}};
        misalign_o = off_i[0];
      end
      default: misalign_o = |off_i;
    endcase
  end

  // Lane 0 (offset 0) is the most significant byte of the bus word.
  always_comb begin
    ld_data_o = rd_data_i;
    case (ld_size_i)
      SIZE_B: begin
        case (ld_off_i)
          2'd0:    ld_data_o = {24'b0, rd_data_i[31:24]};
          2'd1:    ld_data_o = {24'b0, rd_data_i[23:16]};
          2'd2:    ld_data_o = {24'b0, rd_data_i[15:8]};
          default: ld_data_o = {24'b0, rd_data_i[7:0]};
        endcase
      end
      SIZE_S:  ld_data_o = ld_off_i[1] ? {16'b0, rd_data_i[15:0]} : {16'b0, rd_data_i[31:16]};
      default: ld_data_o = rd_data_i;
    endcase
  end

endmodule

// File: rtl/cpu_memory_access.sv
// Mox125 data-memory stage: one Wishbone-classic cycle per load/store,
// pass-through of ALU results otherwise, registered write-back outputs.
module cpu_memory_access
  import cpu_memory_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
  input  logic [1:0]           size_i,
  input  logic [31:0]          memory_address_i,
  input  logic [31:0]          mem_result_i,
  input  logic [31:0]          reg0_result_i,
  input  logic [31:0]          reg1_result_i,
  input  logic [3:0]           register0_write_index_i,
  input  logic [3:0]           register1_write_index_i,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 stall_o,
  output logic                 register_wea_o,
  output logic                 register_web_o,
  output logic [31:0]          reg0_result_o,
  output logic [31:0]          reg1_result_o,
  output logic [3:0]           register0_write_index_o,
  output logic [3:0]           register1_write_index_o,
  output logic                 fault_o
);

  logic        state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  mem_op_t     op_q, op_d;
  logic        flushed_q, flushed_d;
  logic        cyc_q, cyc_d, we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic        wea_q, wea_d, web_q, web_d, fault_q, fault_d;
  logic [31:0] reg0_q, reg0_d, reg1_q, reg1_d;
  logic [3:0]  idx0_q, idx0_d, idx1_q, idx1_d;

  logic [3:0]  lane_sel;
  logic [31:0] lane_wdat, lane_ld;
  logic        lane_mis;
  logic        unused_spare;

  cpu_mem_lane u_lane (
    .size_i     (size_i),
    .off_i      (memory_address_i[1:0]),
    .st_data_i  (mem_result_i),
    .ld_size_i  (op_q.size),
    .ld_off_i   (op_q.off),
    .rd_data_i  (wb_dat_i),
    .sel_o      (lane_sel),
    .wdat_o     (lane_wdat),
    .ld_data_o  (lane_ld),
    .misalign_o (lane_mis)
  );

  assign unused_spare = pipeline_control_bits_i[PCB_SPARE];

  logic is_rm, is_wm, is_mem, go_bus, in_bus, tmo, bus_ok, bus_fail, bus_done;
  assign is_rm  = pipeline_control_bits_i[PCB_RM];
  assign is_wm  = pipeline_control_bits_i[PCB_WM];
  assign is_mem = is_rm | is_wm;
  assign go_bus = (state_q == ST_IDLE) & is_mem & ~lane_mis & ~flush_i;
  assign in_bus = (state_q == ST_BUS);
  // cnt_q counts completed BUS cycles, so the last permitted cycle sees TIMEOUT_CYCLES-1.
  assign tmo      = in_bus & (TIMEOUT_CYCLES != 0) & (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign bus_fail = in_bus & (wb_err_i | (tmo & ~wb_ack_i));
  assign bus_ok   = in_bus & wb_ack_i & ~wb_err_i;
  assign bus_done = bus_ok | bus_fail;
  assign stall_o  = rst_i & (go_bus | (in_bus & ~bus_done));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    flushed_d = flushed_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    wea_d     = 1'b0;
    web_d     = 1'b0;
    fault_d   = 1'b0;
    reg0_d    = reg0_q;
    reg1_d    = reg1_q;
    idx0_d    = idx0_q;
    idx1_d    = idx1_q;
    if (state_q == ST_IDLE) begin
      if (flush_i) begin
        wea_d = 1'b0;
      end else if (is_mem && lane_mis) begin
        fault_d = 1'b1;
      end else if (is_mem) begin
        state_d    = ST_BUS;
        cnt_d      = '0;
        flushed_d  = 1'b0;
        cyc_d      = 1'b1;
        we_d       = is_wm & ~is_rm;
        adr_d      = {memory_address_i[31:2], 2'b00};
        sel_d      = lane_sel;
        dat_d      = lane_wdat;
        op_d.wa    = pipeline_control_bits_i[PCB_WA];
        op_d.wb    = pipeline_control_bits_i[PCB_WB];
        op_d.load  = is_rm;
        op_d.reg0  = reg0_result_i;
        op_d.reg1  = reg1_result_i;
        op_d.idx0  = register0_write_index_i;
        op_d.idx1  = register1_write_index_i;
        op_d.size  = size_i;
        op_d.off   = memory_address_i[1:0];
      end else begin
        wea_d  = pipeline_control_bits_i[PCB_WA];
        web_d  = pipeline_control_bits_i[PCB_WB];
        reg0_d = reg0_result_i;
        reg1_d = reg1_result_i;
        idx0_d = register0_write_index_i;
        idx1_d = register1_write_index_i;
      end
    end else begin
      cnt_d     = cnt_q + 16'd1;
      flushed_d = flushed_q | flush_i;
      if (bus_done) begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        fault_d = bus_fail;
      end
      // A flushed access still completes on the bus; only write-back is dropped.
      if (bus_ok) begin
        reg0_d = op_q.reg0;
        reg1_d = op_q.load ? lane_ld : op_q.reg1;
        idx0_d = op_q.idx0;
        idx1_d = op_q.idx1;
        if (!(flushed_q || flush_i)) begin
          wea_d = op_q.wa;
          web_d = op_q.load | op_q.wb;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      flushed_q <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      wea_q     <= 1'b0;
      web_q     <= 1'b0;
      fault_q   <= 1'b0;
      reg0_q    <= '0;
      reg1_q    <= '0;
      idx0_q    <= '0;
      idx1_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      flushed_q <= flushed_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      wea_q     <= wea_d;
      web_q     <= web_d;
      fault_q   <= fault_d;
      reg0_q    <= reg0_d;
      reg1_q    <= reg1_d;
      idx0_q    <= idx0_d;
      idx1_q    <= idx1_d;
    end
  end

  assign wb_adr_o                = adr_q;
  assign wb_dat_o                = dat_q;
  assign wb_sel_o                = sel_q;
  assign wb_we_o                 = we_q;
  assign wb_cyc_o                = cyc_q;
  assign wb_stb_o                = cyc_q;
  assign register_wea_o          = wea_q;
  assign register_web_o          = web_q;
  assign reg0_result_o           = reg0_q;
  assign reg1_result_o           = reg1_q;
  assign register0_write_index_o = idx0_q;
  assign register1_write_index_o = idx1_q;
  assign fault_o                 = fault_q;

endmodule

// File: tb/tb_cpu_memory_access.sv
// Directed bench for cpu_memory_access with a per-cycle reference model.
module tb_cpu_memory_access;

  localparam int TMO = 16;
  localparam logic [4:0] P_WA = 5'b00001, P_WB = 5'b00010, P_RM = 5'b00100, P_WM = 5'b01000;

  logic clk = 1'b0, rst_i = 1'b0, flush_i = 1'b0;
  logic [4:0] pcb = '0;
  logic [1:0] size_i = '0;
  logic [31:0] addr_i = '0, mres_i = '0, r0_i = '0, r1_i = '0, wb_dat_i = '0;
  logic [3:0] i0_i = '0, i1_i = '0;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o, reg0_o, reg1_o;
  logic [3:0] wb_sel_o, idx0_o, idx1_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o, stall_o, wea_o, web_o, fault_o;

  cpu_memory_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .pipeline_control_bits_i(pcb),
    .size_i(size_i), .memory_address_i(addr_i), .mem_result_i(mres_i),
    .reg0_result_i(r0_i), .reg1_result_i(r1_i),
    .register0_write_index_i(i0_i), .register1_write_index_i(i1_i),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .stall_o(stall_o),
    .register_wea_o(wea_o), .register_web_o(web_o),
    .reg0_result_o(reg0_o), .reg1_result_o(reg1_o),
    .register0_write_index_o(idx0_o), .register1_write_index_o(idx1_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, stall_cnt = 0, cyc_cnt = 0;
  logic chk_en = 1'b0;
  // expectations for the current cycle (exp_*) and for the cycle after the next edge (nxt_*)
  logic exp_stall = 0, exp_cyc = 0, exp_we = 0, exp_wea = 0, exp_web = 0, exp_fault = 0;
  logic [3:0] exp_sel = 0, exp_idx0 = 0, exp_idx1 = 0, nxt_idx0 = 0, nxt_idx1 = 0;
  logic [31:0] exp_dat = 0, exp_adr = 0, exp_reg0 = 0, exp_reg1 = 0, nxt_reg0 = 0, nxt_reg1 = 0;
  logic nxt_wea = 0, nxt_web = 0, nxt_fault = 0;
  logic [3:0] last_sel = 0;
  logic [31:0] last_dat = 0;
  logic last_we = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("stall", stall_o, exp_stall);
    chk("cyc", wb_cyc_o, exp_cyc);
    chk("stb", wb_stb_o, exp_cyc);
    chk("wea", wea_o, exp_wea);
    chk("web", web_o, exp_web);
    chk("fault", fault_o, exp_fault);
    if (exp_cyc) begin
      chk("we", wb_we_o, exp_we);
      chk("sel", wb_sel_o, exp_sel);
      chk("adr", wb_adr_o, exp_adr);
      if (exp_we) chk("wdat", wb_dat_o, exp_dat);
    end
    if (exp_wea) begin chk("reg0", reg0_o, exp_reg0); chk("idx0", idx0_o, exp_idx0); end
    if (exp_web) begin chk("reg1", reg1_o, exp_reg1); chk("idx1", idx1_o, exp_idx1); end
    if (stall_o) stall_cnt++;
    if (wb_cyc_o) begin cyc_cnt++; last_sel = wb_sel_o; last_dat = wb_dat_o; last_we = wb_we_o; end
  end

  // Byte-level view of a big-endian access: n bytes starting at offset o of the word.
  function automatic void model(input logic [1:0] sz, input logic [31:0] addr, sd, rd,
                                output logic [3:0] sel, output logic [31:0] wd, ld,
                                output logic mis);
    int n, o;
    logic [63:0] m, rep;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    o   = int'(addr[1:0]);
    mis = (o % n) != 0;
    sel = 4'b0;
    ld  = 32'b0;
    m   = (64'd1 << (8 * n)) - 64'd1;
    rep = (n == 1) ? 64'h01010101 : (n == 2) ? 64'h00010001 : 64'h1;
    wd  = 32'(({32'b0, sd} & m) * rep);
    if (!mis) begin
      sel = 4'(((1 << n) - 1) << (4 - o - n));
      ld  = 32'(({32'b0, rd} >> (8 * (4 - o - n))) & m);
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    exp_wea = nxt_wea; exp_web = nxt_web; exp_fault = nxt_fault;
    exp_reg0 = nxt_reg0; exp_reg1 = nxt_reg1; exp_idx0 = nxt_idx0; exp_idx1 = nxt_idx1;
    nxt_wea = 0; nxt_web = 0; nxt_fault = 0;
  endtask

  task automatic drive(input logic [4:0] p, input logic [1:0] sz, input logic [31:0] a, sd, r0, r1,
                       input logic [3:0] i0, i1, input logic fl);
    pcb = p; size_i = sz; addr_i = a; mres_i = sd; r0_i = r0; r1_i = r1;
    i0_i = i0; i1_i = i1; flush_i = fl; wb_ack_i = 0; wb_err_i = 0; wb_dat_i = 0;
  endtask

  task automatic nonmem(input logic [4:0] p, input logic [31:0] r0, r1, input logic [3:0] i0, i1,
                        input logic fl);
    tick();
    drive(p, 2'd0, 32'h0, 32'h0, r0, r1, i0, i1, fl);
    exp_stall = 0; exp_cyc = 0;
    if (!fl) begin
      nxt_wea = p[0]; nxt_web = p[1];
      nxt_reg0 = r0; nxt_reg1 = r1; nxt_idx0 = i0; nxt_idx1 = i1;
    end
  endtask

  task automatic idle();
    nonmem(5'd0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic mem_op(input logic [4:0] p, input logic [1:0] sz, input logic [31:0] a, sd, r0, r1,
                        input logic [3:0] i0, i1, input logic [31:0] rd,
                        input int ack_at, err_at, flush_at, rst_at);
    logic [3:0] sel;
    logic [31:0] wd, ld;
    logic mis, load, flushed, ack, err, ev;
    model(sz, a, sd, rd, sel, wd, ld, mis);
    load = p[2];
    tick();
    drive(p, sz, a, sd, r0, r1, i0, i1, 1'b0);
    exp_cyc = 0;
    if (mis) begin
      exp_stall = 0; nxt_fault = 1;
      return;
    end
    exp_stall = 1;
    exp_we = p[3] & ~load; exp_sel = sel; exp_dat = wd; exp_adr = {a[31:2], 2'b00};
    flushed = 0;
    for (int n = 1; n <= TMO; n++) begin
      tick();
      exp_cyc = 1;
      if (n == rst_at) begin
        chk_en = 0; rst_i = 0; #1;
        chk("rst_cyc", wb_cyc_o, 0); chk("rst_stb", wb_stb_o, 0); chk("rst_stall", stall_o, 0);
        chk("rst_wea", wea_o, 0); chk("rst_web", web_o, 0); chk("rst_fault", fault_o, 0);
        chk("rst_reg0", reg0_o, 0); chk("rst_reg1", reg1_o, 0);
        drive(5'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1'b0);
        nxt_wea = 0; nxt_web = 0; nxt_fault = 0;
        exp_wea = 0; exp_web = 0; exp_fault = 0; exp_stall = 0; exp_cyc = 0;
        @(posedge clk); #1; rst_i = 1; chk_en = 1;
        return;
      end
      ack = (n == ack_at); err = (n == err_at);
      wb_ack_i = ack; wb_err_i = err; wb_dat_i = rd;
      flush_i = (n == flush_at);
      if (n == flush_at) flushed = 1;
      ev = ack | err | (n == TMO);
      exp_stall = ~ev;
      if (err) nxt_fault = 1;
      else if (ack) begin
        if (!flushed) begin
          nxt_wea = p[0]; nxt_web = load | p[1];
          nxt_reg0 = r0; nxt_reg1 = load ? ld : r1; nxt_idx0 = i0; nxt_idx1 = i1;
        end
      end else if (ev) nxt_fault = 1;
      if (ev) break;
    end
  endtask

  initial begin
    drive(5'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cyc", wb_cyc_o, 0); chk("reset_stall", stall_o, 0); chk("reset_wea", wea_o, 0);
    chk("reset_web", web_o, 0); chk("reset_fault", fault_o, 0); chk("reset_adr", wb_adr_o, 0);
    chk("reset_sel", wb_sel_o, 0); chk("reset_reg1", reg1_o, 0);
    rst_i = 1; chk_en = 1;

    // LDI pass-through
    nonmem(P_WA, 32'h1234, 32'h0, 4'd3, 4'd0, 1'b0);
    idle(); @(negedge clk);
    chk("t1_wea", wea_o, 1); chk("t1_reg0", reg0_o, 32'h1234); chk("t1_idx0", idx0_o, 3);

    // load byte @0x101, ack on 4th bus cycle
    idle(); stall_cnt = 0;
    mem_op(P_RM, 2'd0, 32'h101, 0, 0, 0, 0, 4'd5, 32'hAABBCCDD, 4, 0, 0, 0);
    idle(); @(negedge clk);
    chk("t2_sel", last_sel, 4'b0100); chk("t2_stall_clks", stall_cnt, 4);
    chk("t2_reg1", reg1_o, 32'h000000BB); chk("t2_web", web_o, 1); chk("t2_idx1", idx1_o, 5);

    // store short @0x202, immediate ack, WA passes $sp update
    mem_op(P_WM | P_WA, 2'd1, 32'h202, 32'h0000BEEF, 32'h55, 0, 4'd2, 0, 0, 1, 0, 0, 0);
    idle(); @(negedge clk);
    chk("t3_we", last_we, 1); chk("t3_sel", last_sel, 4'b0011); chk("t3_dat", last_dat, 32'hBEEFBEEF);
    chk("t3_wea", wea_o, 1); chk("t3_reg0", reg0_o, 32'h55); chk("t3_web", web_o, 0);

    // misaligned long load
    cyc_cnt = 0;
    mem_op(P_RM, 2'd2, 32'h3, 0, 0, 0, 0, 4'd1, 0, 1, 0, 0, 0);
    idle(); @(negedge clk);
    chk("t4_fault", fault_o, 1); chk("t4_web", web_o, 0);
    idle(); @(negedge clk);
    chk("t4_pulse", fault_o, 0); chk("t4_nocyc", cyc_cnt, 0);

    // timeout
    cyc_cnt = 0;
    mem_op(P_RM, 2'd2, 32'h100, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0, 0);
    idle(); @(negedge clk);
    chk("t5_fault", fault_o, 1); chk("t5_cyc", wb_cyc_o, 0); chk("t5_cycles", cyc_cnt, TMO);

    // flush mid-load
    mem_op(P_RM | P_WA, 2'd0, 32'h0, 0, 0, 0, 4'd1, 4'd7, 32'h11223344, 4, 0, 2, 0);
    idle(); @(negedge clk);
    chk("t6_web", web_o, 0); chk("t6_wea", wea_o, 0); chk("t6_sel", last_sel, 4'b1000);

    // ack+err together: err wins
    mem_op(P_RM, 2'd2, 32'h10, 0, 0, 0, 0, 4'd1, 32'h1, 1, 1, 0, 0);
    idle(); @(negedge clk);
    chk("t7_fault", fault_o, 1); chk("t7_web", web_o, 0);

    // load short low half, store byte lane 3, RM+WM as load, misaligned short store
    mem_op(P_RM, 2'd1, 32'h402, 0, 0, 0, 0, 4'd9, 32'h11223344, 2, 0, 0, 0);
    idle(); @(negedge clk);
    chk("t8_reg1", reg1_o, 32'h00003344);
    mem_op(P_WM, 2'd0, 32'h503, 32'h0000005A, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    idle(); @(negedge clk);
    chk("t9_sel", last_sel, 4'b0001); chk("t9_dat", last_dat, 32'h5A5A5A5A);
    mem_op(P_RM | P_WM, 2'd2, 32'h600, 32'hFFFF, 0, 0, 0, 4'd4, 32'hCAFEF00D, 1, 0, 0, 0);
    idle(); @(negedge clk);
    chk("t10_we", last_we, 0); chk("t10_reg1", reg1_o, 32'hCAFEF00D);
    mem_op(P_WM, 2'd1, 32'h701, 32'h1234, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    nonmem(P_WA | P_WB, 32'h77, 32'h88, 4'd1, 4'd2, 1'b1);
    idle(); @(negedge clk);
    chk("t11_flush_wea", wea_o, 0);

    // reset in the middle of a bus cycle
    mem_op(P_RM, 2'd2, 32'h800, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0, 2);
    idle(); idle();
    mem_op(P_RM, 2'd2, 32'h900, 0, 0, 0, 0, 4'd6, 32'h600DF00D, 1, 0, 0, 0);
    idle(); @(negedge clk);
    chk("t12_reg1", reg1_o, 32'h600DF00D);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
